// File: rtl/pipe_reg_r_pkg.sv
// Shared helpers for the factorial machine datapath blocks.
package pipe_reg_r_pkg;

  // Ceiling log2; returns 0 for values of 0 or 1.
  function automatic int unsigned clog2(input int unsigned value);
    int unsigned r;
    int unsigned v;
    r = 0;
    if (value > 1) begin
      for (v = value - 1; v > 0; v = v >> 1) begin
        r = r + 1;
      end
    end
    return r;
  endfunction

  // Width of an occupancy counter able to hold 0..depth.
  function automatic int unsigned cnt_width(input int unsigned depth);
    return clog2(depth + 1);
  endfunction

endpackage

// File: rtl/pipe_stage_r.sv
// One elastic pipeline stage: valid bit plus data register.
module pipe_stage_r #(
  parameter int unsigned          WIDTH       = 32,
  parameter logic [WIDTH-1:0]     RESET_VALUE = '0
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             load,
  input  logic             clear,
  input  logic             src_valid,
  input  logic [WIDTH-1:0] src_data,
  output logic             valid,
  output logic [WIDTH-1:0] data
);

  // Clear drops the valid but keeps data; load copies data only for a real item.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      valid <= 1'b0;
      data  <= RESET_VALUE;
    end else if (clear) begin
      valid <= 1'b0;
    end else if (load) begin
      valid <= src_valid;
      if (src_valid) begin
        data <= src_data;
      end
    end
  end

endmodule

// File: rtl/pipe_reg_r.sv
// Elastic resettable register pipeline with bubble collapsing, flush and count.
module pipe_reg_r
  import pipe_reg_r_pkg::*;
#(
  parameter int unsigned      WIDTH       = 32,
  parameter int unsigned      DEPTH       = 2,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic                         flush,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [WIDTH-1:0]             in_data,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [WIDTH-1:0]             out_data,
  output logic [cnt_width(DEPTH)-1:0]  count
);

  localparam int unsigned CNT_W = cnt_width(DEPTH);

  logic [DEPTH-1:0] v;
  logic [WIDTH-1:0] d [DEPTH];
  logic [DEPTH:0]   rdy;
  logic             in_fire;
  logic             out_fire;

  // Ready chain: a stage accepts when it is empty or the stage ahead is moving.
  always_comb begin
    rdy        = '0;
    rdy[DEPTH] = out_ready;
    for (int k = int'(DEPTH) - 1; k >= 0; k--) begin
      rdy[k] = ~v[k] | rdy[k+1];
    end
  end

  assign in_ready  = rdy[0] & ~flush;
  assign out_valid = v[DEPTH-1] & ~flush;
  assign out_data  = d[DEPTH-1];
  assign in_fire   = in_valid & in_ready;
  assign out_fire  = out_valid & out_ready;

  // Stage array; stage 0 is fed from the upstream port.
  for (genvar k = 0; k < DEPTH; k++) begin : g_stage
    logic             sv;
    logic [WIDTH-1:0] sd;
    if (k == 0) begin : g_head
      assign sv = in_valid;
      assign sd = in_data;
    end else begin : g_body
      assign sv = v[k-1];
      assign sd = d[k-1];
    end
    pipe_stage_r #(
      .WIDTH       (WIDTH),
      .RESET_VALUE (RESET_VALUE)
    ) u_stage (
      .clk       (clk),
      .reset_n   (reset_n),
      .load      (rdy[k]),
      .clear     (flush),
      .src_valid (sv),
      .src_data  (sd),
      .valid     (v[k]),
      .data      (d[k])
    );
  end

  // Occupancy counter tracks push/pop transfers; flush empties it.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count <= '0;
    end else if (flush) begin
      count <= '0;
    end else if (in_fire && !out_fire) begin
      count <= count + CNT_W'(1);
    end else if (out_fire && !in_fire) begin
      count <= count - CNT_W'(1);
    end
  end

endmodule
